// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter: shares one single-port SRAM bank between NUM_REQ requesters.
// Round-robin grant each cycle, optional burst lock capped at MAX_BURST, and
// one-cycle read-return tagging back to the issuing requester.
// Optional feature macro: SRAM_ARB_PERF_CNT_EN enables the grant/conflict
// performance counters; without it both counter outputs are tied to zero.
module sram_bank_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_we,
  input  logic [NUM_REQ-1:0]            i_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REQ-1:0]            o_rvalid,
  output logic [DATA_WIDTH-1:0]         o_rdata,
  output logic                          o_sram_rd_wr_en,
  output logic [ADDR_WIDTH-1:0]         o_sram_addr,
  output logic [DATA_WIDTH-1:0]         o_sram_wdata,
  input  logic [DATA_WIDTH-1:0]         i_sram_rdata,
  output logic [31:0]                   o_grant_cnt,
  output logic [31:0]                   o_conflict_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {S_ARB, S_LOCK} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_c;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] owner_oh;
  logic [PTR_W-1:0]   win_idx;
  logic               do_arb;
  logic [NUM_REQ-1:0] vld_p1;

  // (ptr + i) mod NUM_REQ without relying on NUM_REQ being a power of two
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int unsigned inc);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + (PTR_W+1)'(inc);
    if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
    return sum[PTR_W-1:0];
  endfunction

  // First requester at or after ptr, wrapping; returns one-hot
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [PTR_W-1:0] ptr);
    logic [NUM_REQ-1:0] g;
    logic               found;
    logic [PTR_W-1:0]   idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = wrap_add(ptr, i);
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  // One-hot to index
  function automatic logic [PTR_W-1:0] enc(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

  // Arbiter control state: rr pointer, FSM, burst owner and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and grant: burst owner holds the bank, otherwise round-robin
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gnt_c    = '0;
    arb_req  = i_req;
    do_arb   = 1'b1;
    win_idx  = '0;
    owner_oh = '0;
    owner_oh[owner_q] = 1'b1;
    if (state_q == S_LOCK) begin
      if (i_req[owner_q] && i_lock[owner_q] && (cnt_q < CNT_W'(MAX_BURST))) begin
        gnt_c[owner_q] = 1'b1;
        cnt_d          = cnt_q + 1'b1;
        do_arb         = 1'b0;
      end else begin
        // Exit re-arbitrates in the same cycle; a capped owner yields if anyone else waits
        state_d = S_ARB;
        cnt_d   = '0;
        if ((cnt_q == CNT_W'(MAX_BURST)) && ((i_req & ~owner_oh) != '0))
          arb_req = i_req & ~owner_oh;
      end
    end
    if (do_arb) begin
      gnt_c = rr_pick(arb_req, ptr_q);
      if (gnt_c != '0) begin
        win_idx = enc(gnt_c);
        ptr_d   = wrap_add(win_idx, 1);
        if (i_lock[win_idx] && (MAX_BURST > 1)) begin
          state_d = S_LOCK;
          owner_d = win_idx;
          cnt_d   = CNT_W'(1);
        end
      end
    end
  end

  assign o_gnt = rst_n ? gnt_c : '0;

  // Bank pin mux: granted requester drives we/addr/wdata, idle drives zero
  always_comb begin
    o_sram_rd_wr_en = 1'b0;
    o_sram_addr     = '0;
    o_sram_wdata    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (o_gnt[k]) begin
        o_sram_rd_wr_en = i_we[k];
        o_sram_addr     = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        o_sram_wdata    = i_wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---- stage p1: read-return tag, aligned with the bank's registered data ----
  // Tag the granted read so the returning word is routed to its issuer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= '0;
    else        vld_p1 <= o_gnt & ~i_we;
  end

  assign o_rvalid = vld_p1;
  assign o_rdata  = i_sram_rdata;

`ifdef SRAM_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt_q, conflict_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Saturating perf counters: cycles with a grant, cycles with contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (o_gnt != '0)            grant_cnt_q    <= sat_inc(grant_cnt_q);
      if ($countones(i_req) >= 2) conflict_cnt_q <= sat_inc(conflict_cnt_q);
    end
  end

  assign o_grant_cnt    = grant_cnt_q;
  assign o_conflict_cnt = conflict_cnt_q;
`else
  assign o_grant_cnt    = 32'd0;
  assign o_conflict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter with a registered-read bank model.
module tb_sram_bank_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int MB = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    i_req, i_we, i_lock;
  logic [NR*AW-1:0] i_addr;
  logic [NR*DW-1:0] i_wdata;
  logic [NR-1:0]    o_gnt, o_rvalid;
  logic [DW-1:0]    o_rdata;
  logic             o_sram_rd_wr_en;
  logic [AW-1:0]    o_sram_addr;
  logic [DW-1:0]    o_sram_wdata;
  logic [DW-1:0]    i_sram_rdata;
  logic [31:0]      o_grant_cnt, o_conflict_cnt;

  int checks   = 0;
  int failures = 0;

  sram_bank_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_we(i_we), .i_lock(i_lock),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_gnt(o_gnt), .o_rvalid(o_rvalid),
    .o_rdata(o_rdata), .o_sram_rd_wr_en(o_sram_rd_wr_en), .o_sram_addr(o_sram_addr),
    .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata),
    .o_grant_cnt(o_grant_cnt), .o_conflict_cnt(o_conflict_cnt)
  );

  always #5 clk = ~clk;

  // Single-port bank with registered read data
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (o_sram_rd_wr_en) mem[o_sram_addr] <= o_sram_wdata;
    i_sram_rdata <= mem[o_sram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after the falling edge, settle, then let the caller check
  task automatic cyc(input logic [NR-1:0] req, input logic [NR-1:0] we, input logic [NR-1:0] lock);
    @(negedge clk);
    i_req  = req;
    i_we   = we;
    i_lock = lock;
    #1;
  endtask

  logic [31:0] exp_gcnt, exp_ccnt;

  initial begin
    rst_n   = 1'b0;
    i_req   = '0;
    i_we    = '0;
    i_lock  = '0;
    i_addr  = {10'd19, 10'd18, 10'd17, 10'd16};
    i_wdata = {8'h44, 8'h33, 8'h22, 8'h11};

    // Reset held with random requests
    for (int i = 0; i < 3; i++) begin
      cyc(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      chk("rst_gnt", o_gnt, 0);
      chk("rst_rvalid", o_rvalid, 0);
      chk("rst_we", o_sram_rd_wr_en, 0);
      chk("rst_addr", o_sram_addr, 0);
      chk("rst_gcnt", o_grant_cnt, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    i_req = '0; i_we = '0; i_lock = '0;
    #1;
    chk("idle_gnt", o_gnt, 0);

    // Round robin from pointer 0, all reads
    for (int i = 0; i < 8; i++) begin
      cyc(4'hF, 4'h0, 4'h0);
      chk("rr_gnt", o_gnt, 1 << (i % 4));
      chk("rr_addr", o_sram_addr, 16 + (i % 4));
      if (i > 0) chk("rr_rvalid", o_rvalid, 1 << ((i - 1) % 4));
    end
    cyc(4'h0, 4'h0, 4'h0);
    chk("rr_rvalid_last", o_rvalid, 4'b1000);
    chk("rr_gnt_none", o_gnt, 0);

    // Write 0xA5 to address 5 then read it back, both from requester 0
    i_addr[0 +: AW]  = 10'd5;
    i_wdata[0 +: DW] = 8'hA5;
    cyc(4'b0001, 4'b0001, 4'b0000);
    chk("wr_gnt", o_gnt, 4'b0001);
    chk("wr_en", o_sram_rd_wr_en, 1);
    chk("wr_addr", o_sram_addr, 5);
    chk("wr_data", o_sram_wdata, 8'hA5);
    cyc(4'b0001, 4'b0000, 4'b0000);
    chk("wr_no_rvalid", o_rvalid, 0);
    chk("rd_gnt", o_gnt, 4'b0001);
    chk("rd_en", o_sram_rd_wr_en, 0);
    cyc(4'b0000, 4'b0000, 4'b0000);
    chk("rd_rvalid", o_rvalid, 4'b0001);
    chk("rd_data", o_rdata, 8'hA5);

    // Burst cap: pointer is 1; requester 1 locks, requester 2 waits
    for (int i = 0; i < MB; i++) begin
      cyc(4'b0110, 4'b0000, 4'b0010);
      chk("burst_gnt1", o_gnt, 4'b0010);
    end
    cyc(4'b0110, 4'b0000, 4'b0010);
    chk("burst_forced_rot", o_gnt, 4'b0100);
    cyc(4'b0110, 4'b0000, 4'b0010);
    chk("burst_regain", o_gnt, 4'b0010);
    cyc(4'b0000, 4'b0000, 4'b0010);
    chk("burst_drop_req", o_gnt, 0);

    // Early unlock: pointer is 2; requester 3 locks for 3 cycles, 0 pending
    cyc(4'b1000, 4'b0000, 4'b1000);
    chk("unlock_gnt3_a", o_gnt, 4'b1000);
    cyc(4'b1001, 4'b0000, 4'b1000);
    chk("unlock_gnt3_b", o_gnt, 4'b1000);
    cyc(4'b1001, 4'b0000, 4'b1000);
    chk("unlock_gnt3_c", o_gnt, 4'b1000);
    cyc(4'b1001, 4'b0000, 4'b0000);
    chk("unlock_gnt0", o_gnt, 4'b0001);

    // Reset mid-burst: pointer is 1; requester 2 locks, then reset hits
    cyc(4'b0100, 4'b0000, 4'b0100);
    chk("mid_lock_gnt", o_gnt, 4'b0100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", o_gnt, 0);
    chk("mid_rst_rvalid", o_rvalid, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    i_req  = 4'b0110;
    i_lock = 4'b0100;
    #1;
    chk("mid_rel_gnt", o_gnt, 4'b0010);

    // Perf counters from a clean reset
    @(negedge clk);
    rst_n = 1'b0;
    i_req = '0; i_lock = '0; i_we = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc(4'b0011, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++)  cyc(4'b0001, 4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000, 4'b0000);
`ifdef SRAM_ARB_PERF_CNT_EN
    exp_gcnt = 32'd15;
    exp_ccnt = 32'd10;
`else
    exp_gcnt = 32'd0;
    exp_ccnt = 32'd0;
`endif
    chk("perf_grant", o_grant_cnt, exp_gcnt);
    chk("perf_conflict", o_conflict_cnt, exp_ccnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
